param_memory: RTL and testbench
===============================

PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, address port width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, number of words, 2..2**ADDR_W, not required to be a power of two.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles, legal range 1..4.
REQ-005 SHALL have parameter BOOT_WORD, default 16'b0010011111100111, the word written to address 0 after clear.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port CLK, input, 1, rising-edge clock.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port MemRead, input, 1, read request, sampled at the clock edge.
REQ-010 SHALL have port MemWrite, input, 1, write request, sampled at the clock edge.
REQ-011 SHALL have port ADDR, input, ADDR_W, word address.
REQ-012 SHALL have port Data_in, input, DATA_W, write data.
REQ-013 SHALL have port Data_out, output, DATA_W, registered read data.
REQ-014 SHALL have port rd_valid, output, 1, one-cycle pulse qualifying Data_out.
REQ-015 SHALL have port ready, output, 1, high only when requests are accepted.
REQ-016 SHALL have port addr_err, output, 1, one-cycle pulse flagging an out-of-range request.

Function
REQ-017 SHALL implement FSM states CLEAR, LOAD and RUN; ready=1 only in RUN.
REQ-018 In CLEAR, each edge SHALL write 0 to mem[idx] and increment idx; at idx==DEPTH-1 the FSM SHALL write that last word and go to LOAD.
REQ-019 LOAD SHALL write BOOT_WORD to mem[0] in one edge, then go to RUN; ready SHALL rise exactly DEPTH+1 edges after reset deasserts.
REQ-020 RUN is terminal; only reset SHALL leave it.
REQ-021 MemRead/MemWrite with ready=0 SHALL be ignored: no array change, no rd_valid, no addr_err.
REQ-022 A write accepted at edge N with ADDR<DEPTH SHALL update mem[ADDR] at edge N.
REQ-023 A read accepted at edge N SHALL drive Data_out=mem[ADDR] (value before any write at edge N) with rd_valid=1 for exactly one cycle after edge N+RD_LAT-1.
REQ-024 Simultaneous read+write, same address, SHALL be read-first (old data returned); the write still commits.
REQ-025 Reads SHALL sustain one per cycle; consecutive rd_valid pulses SHALL be back-to-back in request order.
REQ-026 Data_out SHALL hold its last value whenever rd_valid=0.
REQ-027 ADDR>=DEPTH, compared at full ADDR_W width: a write SHALL be dropped; a read SHALL return 0 with a normal rd_valid; addr_err SHALL pulse one cycle after the request edge.
REQ-028 Both MemRead and MemWrite out of range SHALL give a single addr_err pulse.

Reset
REQ-029 On any edge with reset=1: state<=CLEAR, idx<=0, Data_out<=0, rd_valid<=0, addr_err<=0, ready<=0, read pipeline flushed.
REQ-030 Reset mid-read SHALL suppress every outstanding rd_valid.
REQ-031 Reset during CLEAR or LOAD SHALL restart CLEAR from idx 0.

Structure
REQ-032 Shared package mem_pkg SHALL hold the FSM state encoding, parameter defaults and BOOT_WORD.
REQ-033 Sub-module rd_pipe SHALL implement the RD_LAT-stage valid/data delay line with synchronous flush.
REQ-034 The array SHALL be DEPTH x DATA_W registers, with no combinational path from inputs to outputs.

Verification (DEPTH=16, RD_LAT=2)
REQ-035 Release reset, hold MemRead=1, ADDR=0 -> ready=0 for 17 cycles; first accepted read returns 16'h27E7, rd_valid 2 cycles later.
REQ-036 Write 16'hA5A5 to addr 5, then read addr 5 -> Data_out=16'hA5A5; read addr 6 -> 16'h0000.
REQ-037 Same edge: write 16'h1234 to addr 3 and read addr 3 (old 0) -> returns 0; the next read returns 16'h1234.
REQ-038 Write then read ADDR=16 -> addr_err pulses each time, read returns 0, addr 0 still holds 16'h27E7.
REQ-039 Reads to addrs 1,2,3 on consecutive edges, then reset one cycle later -> at most the first rd_valid appears; none after reset; all words 0 except addr 0 after the new CLEAR/LOAD.
REQ-040 Requests issued during CLEAR -> no rd_valid, no addr_err, array unchanged from its cleared state.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for param_memory: parameter defaults, boot word and
// the CLEAR/LOAD/RUN state encoding.
package mem_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned RD_LAT_DEF = 1;

  localparam logic [15:0] BOOT_WORD_DEF = 16'b0010011111100111;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/param_memory_if.sv
// Request/response bus of param_memory.
//   MemRead, MemWrite, ADDR, Data_in : requests (master -> slave)
//   Data_out, rd_valid               : registered read response
//   ready                            : high only while requests are accepted
//   addr_err                         : one-cycle out-of-range flag
interface param_memory_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);

  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Data_in;
  logic [DATA_W-1:0] Data_out;
  logic              rd_valid;
  logic              ready;
  logic              addr_err;

  modport master (
    output MemRead, MemWrite, ADDR, Data_in,
    input  Data_out, rd_valid, ready, addr_err
  );

  modport slave (
    input  MemRead, MemWrite, ADDR, Data_in,
    output Data_out, rd_valid, ready, addr_err
  );

endinterface

// File: rtl/rd_pipe.sv
// RD_LAT-stage valid/data delay line with synchronous flush.
//   clk, flush         : clock and synchronous clear of all stages
//   in_valid, in_data  : stage-0 load
//   out_valid, out_data: last stage; out_data holds while no valid arrives
module rd_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT-1:0] v;
  logic [DATA_W-1:0] d [RD_LAT];

  // Data registers only load behind a valid, so the last stage holds its value.
  always_ff @(posedge clk) begin
    if (flush) begin
      v <= '0;
      for (int i = 0; i < RD_LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[RD_LAT-1];
  assign out_data  = d[RD_LAT-1];

endmodule

// File: rtl/param_memory.sv
// Register-array memory that clears itself, loads BOOT_WORD at address 0,
// then serves read/write requests with RD_LAT cycles of read latency.
//   CLK   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : request/response interface (slave side)
module param_memory
  import mem_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DEPTH     = DEPTH_DEF,
  parameter int unsigned       RD_LAT    = RD_LAT_DEF,
  parameter logic [DATA_W-1:0] BOOT_WORD = DATA_W'(BOOT_WORD_DEF)
) (
  input logic           CLK,
  input logic           reset,
  param_memory_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [1:0]        state, state_next;
  logic [IDX_W-1:0]  idx;
  logic              ready_q, addr_err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range, run, acc_rd, acc_wr;
  logic [IDX_W-1:0]  addr_idx;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_wa;
  logic [DATA_W-1:0] mem_wd, rd_data;

  // Range check is done one bit wider so DEPTH == 2**ADDR_W works.
  assign in_range = CMP_W'(bus.ADDR) < CMP_W'(DEPTH);
  assign addr_idx = bus.ADDR[IDX_W-1:0];
  assign run      = (state == ST_RUN);
  assign acc_rd   = run && bus.MemRead;
  assign acc_wr   = run && bus.MemWrite;
  assign rd_data  = in_range ? mem[addr_idx] : '0;

  // Next state and array write port.
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_wa     = '0;
    mem_wd     = '0;
    case (state)
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = idx;
        if (idx == LAST_IDX) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        mem_we     = 1'b1;
        mem_wd     = BOOT_WORD;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (acc_wr && in_range) begin
          mem_we = 1'b1;
          mem_wa = addr_idx;
          mem_wd = bus.Data_in;
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  // State, clear index and status flags.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= ST_CLEAR;
      idx        <= '0;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_CLEAR) idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      ready_q    <= (state_next == ST_RUN);
      addr_err_q <= (acc_rd || acc_wr) && !in_range;
    end
  end

  // Storage array; the read above sees the pre-write value (read-first).
  always_ff @(posedge CLK) begin
    if (mem_we && !reset) mem[mem_wa] <= mem_wd;
  end

  rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (CLK),
    .flush     (reset),
    .in_valid  (acc_rd),
    .in_data   (rd_data),
    .out_valid (bus.rd_valid),
    .out_data  (bus.Data_out)
  );

  assign bus.ready    = ready_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_param_memory.sv
// Directed self-checking bench for param_memory (DEPTH=16, RD_LAT=2).
module tb_param_memory;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  param_memory_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  param_memory #(
    .DATA_W (16),
    .ADDR_W (16),
    .DEPTH  (16),
    .RD_LAT (2)
  ) dut (
    .CLK   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one read; report addr_err after the request edge and the response one edge later.
  task automatic rd(input logic [15:0] a, output logic ae, output logic v, output logic [15:0] d);
    bus.MemRead = 1'b1;
    bus.ADDR    = a;
    tick();
    ae = bus.addr_err;
    bus.MemRead = 1'b0;
    tick();
    v = bus.rd_valid;
    d = bus.Data_out;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] data);
    bus.MemWrite = 1'b1;
    bus.ADDR     = a;
    bus.Data_in  = data;
    tick();
    bus.MemWrite = 1'b0;
  endtask

  // Release reset with requests active and count edges until ready; flags any response meanwhile.
  task automatic boot_count(input logic [15:0] a, output int edges, output logic bad);
    bad   = 1'b0;
    edges = -1;
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b1;
    bus.ADDR     = a;
    bus.Data_in  = 16'hFFFF;
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.rd_valid || bus.addr_err) bad = 1'b1;
      if (bus.ready) begin
        edges = k;
        break;
      end
    end
    bus.MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.addr_err !== 1'b0 || bus.Data_out !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b rd_valid=%b addr_err=%b Data_out=%h, expected 0 0 0 0000",
               bus.ready, bus.rd_valid, bus.addr_err, bus.Data_out);
    end
  endtask

  task automatic test_boot();
    int   edges;
    logic bad;
    boot_count(16'h0000, edges, bad);
    n_checks++;
    if (edges !== 17) begin
      n_fail++;
      $display("FAIL boot_ready_edges: got %0d expected 17", edges);
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_ignored_requests: got response during CLEAR/LOAD, expected none");
    end
    // MemRead still high: accepted at the next edge.
    tick();
    bus.MemRead = 1'b0;
    n_checks++;
    if (bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_latency_early: rd_valid=%b expected 0", bus.rd_valid);
    end
    tick();
    n_checks++;
    if (bus.rd_valid !== 1'b1 || bus.Data_out !== 16'h27E7) begin
      n_fail++;
      $display("FAIL boot_word: rd_valid=%b Data_out=%h expected 1 27e7", bus.rd_valid, bus.Data_out);
    end
    tick();
    n_checks++;
    if (bus.rd_valid !== 1'b0 || bus.Data_out !== 16'h27E7) begin
      n_fail++;
      $display("FAIL data_hold: rd_valid=%b Data_out=%h expected 0 27e7", bus.rd_valid, bus.Data_out);
    end
  endtask

  task automatic test_write_read();
    logic ae, v;
    logic [15:0] d;
    wr(16'd5, 16'hA5A5);
    rd(16'd5, ae, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 16'hA5A5 || ae !== 1'b0) begin
      n_fail++;
      $display("FAIL read_addr5: v=%b d=%h ae=%b expected 1 a5a5 0", v, d, ae);
    end
    rd(16'd6, ae, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin
      n_fail++;
      $display("FAIL read_addr6: v=%b d=%h expected 1 0000", v, d);
    end
  endtask

  task automatic test_read_first();
    logic ae, v;
    logic [15:0] d;
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b1;
    bus.ADDR     = 16'd3;
    bus.Data_in  = 16'h1234;
    tick();
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    tick();
    n_checks++;
    if (bus.rd_valid !== 1'b1 || bus.Data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL read_first_old: v=%b d=%h expected 1 0000", bus.rd_valid, bus.Data_out);
    end
    rd(16'd3, ae, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 16'h1234) begin
      n_fail++;
      $display("FAIL read_first_new: v=%b d=%h expected 1 1234", v, d);
    end
  endtask

  task automatic test_addr_err();
    logic ae, v;
    logic [15:0] d;
    wr(16'd16, 16'hBEEF);
    n_checks++;
    if (bus.addr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_oor_err: addr_err=%b expected 1", bus.addr_err);
    end
    tick();
    n_checks++;
    if (bus.addr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_oor_pulse: addr_err=%b expected 0", bus.addr_err);
    end
    rd(16'd16, ae, v, d);
    n_checks++;
    if (ae !== 1'b1 || v !== 1'b1 || d !== 16'h0000 || bus.addr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_oor: ae=%b v=%b d=%h ae_next=%b expected 1 1 0000 0", ae, v, d, bus.addr_err);
    end
    // Upper address bits must not alias into the array.
    wr(16'h0015, 16'hDEAD);
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b1;
    bus.ADDR     = 16'hFFFF;
    bus.Data_in  = 16'hDEAD;
    tick();
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    n_checks++;
    if (bus.addr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_oor_err: addr_err=%b expected 1", bus.addr_err);
    end
    tick();
    n_checks++;
    if (bus.addr_err !== 1'b0 || bus.rd_valid !== 1'b1 || bus.Data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL rw_oor_single: ae=%b v=%b d=%h expected 0 1 0000", bus.addr_err, bus.rd_valid, bus.Data_out);
    end
    rd(16'd0, ae, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 16'h27E7) begin
      n_fail++;
      $display("FAIL addr0_intact: v=%b d=%h expected 1 27e7", v, d);
    end
    rd(16'd5, ae, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL addr5_intact: v=%b d=%h expected 1 a5a5", v, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h1111;
    exp_d[1] = 16'h2222;
    exp_d[2] = 16'h1234;
    wr(16'd1, 16'h1111);
    wr(16'd2, 16'h2222);
    bus.MemRead = 1'b1;
    bus.ADDR    = 16'd1;
    tick();
    bus.ADDR = 16'd2;
    tick();
    n_checks++;
    if (bus.rd_valid !== 1'b1 || bus.Data_out !== exp_d[0]) begin
      n_fail++;
      $display("FAIL b2b_0: v=%b d=%h expected 1 %h", bus.rd_valid, bus.Data_out, exp_d[0]);
    end
    bus.ADDR = 16'd3;
    tick();
    bus.MemRead = 1'b0;
    n_checks++;
    if (bus.rd_valid !== 1'b1 || bus.Data_out !== exp_d[1]) begin
      n_fail++;
      $display("FAIL b2b_1: v=%b d=%h expected 1 %h", bus.rd_valid, bus.Data_out, exp_d[1]);
    end
    tick();
    n_checks++;
    if (bus.rd_valid !== 1'b1 || bus.Data_out !== exp_d[2]) begin
      n_fail++;
      $display("FAIL b2b_2: v=%b d=%h expected 1 %h", bus.rd_valid, bus.Data_out, exp_d[2]);
    end
    tick();
    n_checks++;
    if (bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: v=%b expected 0", bus.rd_valid);
    end
  endtask

  task automatic test_reset_mid_read();
    int   edges;
    logic bad;
    logic ae, v;
    logic [15:0] d;
    logic [15:0] exp_d;
    bus.MemRead = 1'b1;
    bus.ADDR    = 16'd1;
    tick();
    bus.ADDR = 16'd2;
    tick();
    n_checks++;
    if (bus.rd_valid !== 1'b1 || bus.Data_out !== 16'h1111) begin
      n_fail++;
      $display("FAIL midrd_first: v=%b d=%h expected 1 1111", bus.rd_valid, bus.Data_out);
    end
    bus.ADDR = 16'd3;
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.rd_valid !== 1'b0 || bus.Data_out !== 16'h0 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrd_flush: v=%b d=%h ready=%b expected 0 0000 0", bus.rd_valid, bus.Data_out, bus.ready);
    end
    tick();
    n_checks++;
    if (bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrd_none_after: v=%b expected 0", bus.rd_valid);
    end
    // Abort CLEAR partway through; the restart must take the full count again.
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    boot_count(16'd7, edges, bad);
    bus.MemRead = 1'b0;
    n_checks++;
    if (edges !== 17) begin
      n_fail++;
      $display("FAIL restart_ready_edges: got %0d expected 17", edges);
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_ignored_requests: got response during CLEAR/LOAD, expected none");
    end
    tick();
    tick();
    for (int a = 0; a < 16; a++) begin
      exp_d = (a == 0) ? 16'h27E7 : 16'h0000;
      rd(16'(a), ae, v, d);
      n_checks++;
      if (v !== 1'b1 || d !== exp_d) begin
        n_fail++;
        $display("FAIL recleared_addr%0d: v=%b d=%h expected 1 %h", a, v, d, exp_d);
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.ADDR     = '0;
    bus.Data_in  = '0;
    test_reset();
    test_boot();
    test_write_read();
    test_read_first();
    test_addr_err();
    test_back_to_back();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
